// File: rtl/enemy_sprite_gen.sv
// enemy_sprite_gen
//   Enemy sprite pixel stage. Drives the sprite RAM read address from the
//   scan position relative to the enemy's top-left corner. Takes the
//   registered RAM data one cycle later, treats KEY_COLOR as transparent,
//   and overlays the result on the incoming video. Also owns the enemy
//   position, with a left/right patrol FSM stepped once per frame.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   x, y                current scan column / row
//   frame_tick          one-cycle pulse at frame start
//   move_en             patrol enable
//   pos_wr, pos_x/y     direct position load (priority over frame_tick)
//   ram_addr, ram_dout  sprite RAM read port (data valid one cycle after addr)
//   vin_rgb, vout_rgb   video in / composited video out (2-cycle latency)
//   sprite_on           vout_rgb carries an opaque sprite pixel
//   enemy_x, enemy_y    current top-left position
//   dir_left            patrol currently moving left
module enemy_sprite_gen #(
    parameter int          CD        = 12,
    parameter int          ADDR      = 12,
    parameter logic [CD-1:0] KEY_COLOR = 12'hF0F,
    parameter int          H_SIZE    = 640,
    parameter int          SPEED     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     x,
    input  logic [10:0]     y,
    input  logic            frame_tick,
    input  logic            move_en,
    input  logic            pos_wr,
    input  logic [10:0]     pos_x,
    input  logic [10:0]     pos_y,
    output logic [ADDR-1:0] ram_addr,
    input  logic [CD-1:0]   ram_dout,
    input  logic [CD-1:0]   vin_rgb,
    output logic [CD-1:0]   vout_rgb,
    output logic            sprite_on,
    output logic [10:0]     enemy_x,
    output logic [10:0]     enemy_y,
    output logic            dir_left
);

    localparam int HALF = ADDR / 2;
    localparam int W    = 2 ** HALF;

    typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [10:0] ex_nxt, ey_nxt;

    // ---------------- hit test / address ----------------
    // 12-bit compare so enemy_x + W - 1 cannot wrap.
    logic [11:0]     x12, y12, ex12, ey12;
    logic            hit;
    logic [HALF-1:0] dx, dy;

    assign x12  = {1'b0, x};
    assign y12  = {1'b0, y};
    assign ex12 = {1'b0, enemy_x};
    assign ey12 = {1'b0, enemy_y};

    assign hit = (x12 >= ex12) && (x12 <= ex12 + 12'(W - 1)) &&
                 (y12 >= ey12) && (y12 <= ey12 + 12'(W - 1));

    // Only the low bits of the offset matter once hit is known.
    assign dx = x[HALF-1:0] - enemy_x[HALF-1:0];
    assign dy = y[HALF-1:0] - enemy_y[HALF-1:0];

    assign ram_addr = hit ? {dy, dx} : '0;

    // ---------------- render pipeline ----------------
    // Stage 1 lines hit/video up with the RAM's registered read.
    logic          hit_d1;
    logic [CD-1:0] vin_rgb_d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_d1     <= 1'b0;
            vin_rgb_d1 <= '0;
            vout_rgb   <= '0;
            sprite_on  <= 1'b0;
        end else begin
            hit_d1     <= hit;
            vin_rgb_d1 <= vin_rgb;
            if (hit_d1 && (ram_dout != KEY_COLOR)) begin
                vout_rgb  <= ram_dout;
                sprite_on <= 1'b1;
            end else begin
                vout_rgb  <= vin_rgb_d1;
                sprite_on <= 1'b0;
            end
        end
    end

    // ---------------- patrol FSM ----------------
    logic right_over, left_under;

    assign right_over = (ex12 + 12'(W) + 12'(SPEED)) > 12'(H_SIZE);
    assign left_under = ex12 < 12'(SPEED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RIGHT;
            enemy_x <= '0;
            enemy_y <= '0;
        end else begin
            state   <= state_nxt;
            enemy_x <= ex_nxt;
            enemy_y <= ey_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ex_nxt    = enemy_x;
        ey_nxt    = enemy_y;
        if (pos_wr) begin
            // Load wins; a coincident frame tick is dropped.
            ex_nxt = pos_x;
            ey_nxt = pos_y;
        end else if (frame_tick && move_en) begin
            case (state)
                RIGHT: begin
                    if (right_over) begin
                        ex_nxt    = 11'(H_SIZE - W);
                        state_nxt = LEFT;
                    end else begin
                        ex_nxt = enemy_x + 11'(SPEED);
                    end
                end
                LEFT: begin
                    if (left_under) begin
                        ex_nxt    = '0;
                        state_nxt = RIGHT;
                    end else begin
                        ex_nxt = enemy_x - 11'(SPEED);
                    end
                end
                default: state_nxt = RIGHT;
            endcase
        end
    end

    always_comb begin
        dir_left = (state == LEFT);
    end

endmodule

// File: tb/tb_enemy_sprite_gen.sv
module tb_enemy_sprite_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y, pos_x, pos_y;
    logic        frame_tick, move_en, pos_wr;
    logic [11:0] ram_addr;
    logic [11:0] ram_dout;
    logic [11:0] vin_rgb, vout_rgb;
    logic        sprite_on, dir_left;
    logic [10:0] enemy_x, enemy_y;

    logic [11:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Sprite RAM model: registered read.
    always @(posedge clk) ram_dout <= mem[ram_addr];

    enemy_sprite_gen dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .frame_tick(frame_tick), .move_en(move_en),
        .pos_wr(pos_wr), .pos_x(pos_x), .pos_y(pos_y),
        .ram_addr(ram_addr), .ram_dout(ram_dout),
        .vin_rgb(vin_rgb), .vout_rgb(vout_rgb), .sprite_on(sprite_on),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .dir_left(dir_left)
    );

    typedef struct {
        logic [10:0] px, py;
        logic [10:0] sx, sy;
        logic [11:0] vin;
        logic [11:0] memv;
        logic [11:0] exp_addr;
        logic        exp_on;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pos(input logic [10:0] px, input logic [10:0] py);
        pos_x  = px;
        pos_y  = py;
        pos_wr = 1'b1;
        step();
        pos_wr = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'h000;

        //          px   py   sx   sy   vin     memv    addr    on  rgb
        vecs[0] = '{0,   0,   5,   5,   12'h123, 12'h0A0, 12'h145, 1, 12'h0A0};
        vecs[1] = '{0,   0,   5,   5,   12'h123, 12'hF0F, 12'h145, 0, 12'h123};
        vecs[2] = '{100, 50,  99,  50,  12'h321, 12'h777, 12'h000, 0, 12'h321};
        vecs[3] = '{100, 50,  164, 50,  12'h456, 12'h777, 12'h000, 0, 12'h456};
        vecs[4] = '{100, 50,  100, 50,  12'h111, 12'hABC, 12'h000, 1, 12'hABC};
        vecs[5] = '{100, 50,  163, 50,  12'h222, 12'h0F0, 12'h03F, 1, 12'h0F0};
        vecs[6] = '{100, 50,  100, 113, 12'h333, 12'h00F, 12'hFC0, 1, 12'h00F};
        vecs[7] = '{100, 50,  100, 114, 12'h444, 12'h555, 12'h000, 0, 12'h444};
        vecs[8] = '{100, 50,  100, 49,  12'h666, 12'h555, 12'h000, 0, 12'h666};

        reset = 1'b1; x = 0; y = 0; frame_tick = 0; move_en = 0;
        pos_wr = 0; pos_x = 0; pos_y = 0; vin_rgb = 0;
        step(); step();
        check("rst_vout", vout_rgb, 12'h000);
        check("rst_on", {11'd0, sprite_on}, 12'd0);
        check("rst_ex", {1'b0, enemy_x}, 12'd0);
        check("rst_ey", {1'b0, enemy_y}, 12'd0);
        check("rst_dir", {11'd0, dir_left}, 12'd0);
        reset = 1'b0;

        // Render vectors
        for (int i = 0; i < 9; i++) begin
            load_pos(vecs[i].px, vecs[i].py);
            x = vecs[i].sx; y = vecs[i].sy; vin_rgb = vecs[i].vin;
            mem[vecs[i].exp_addr] = vecs[i].memv;
            #1;
            check($sformatf("v%0d_addr", i), ram_addr, vecs[i].exp_addr);
            step(); step();
            check($sformatf("v%0d_on", i), {11'd0, sprite_on}, {11'd0, vecs[i].exp_on});
            check($sformatf("v%0d_rgb", i), vout_rgb, vecs[i].exp_rgb);
        end

        // Right edge clamp and turn
        move_en = 1'b1;
        load_pos(11'd575, 11'd7);
        tick();
        check("r1_ex", {1'b0, enemy_x}, 12'd576);
        check("r1_dir", {11'd0, dir_left}, 12'd0);
        tick();
        check("r2_ex", {1'b0, enemy_x}, 12'd576);
        check("r2_dir", {11'd0, dir_left}, 12'd1);
        tick();
        check("r3_ex", {1'b0, enemy_x}, 12'd575);
        check("r3_ey", {1'b0, enemy_y}, 12'd7);

        // Left edge clamp and turn
        load_pos(11'd0, 11'd7);
        check("l0_dir", {11'd0, dir_left}, 12'd1);
        tick();
        check("l1_ex", {1'b0, enemy_x}, 12'd0);
        check("l1_dir", {11'd0, dir_left}, 12'd0);

        // pos_wr beats frame_tick
        pos_x = 11'd10; pos_wr = 1'b1; frame_tick = 1'b1;
        step();
        pos_wr = 1'b0; frame_tick = 1'b0;
        check("pw_ex", {1'b0, enemy_x}, 12'd10);
        check("pw_dir", {11'd0, dir_left}, 12'd0);

        // Hold with move_en low
        move_en = 1'b0;
        tick(); tick(); tick();
        check("hold_ex", {1'b0, enemy_x}, 12'd10);
        check("hold_dir", {11'd0, dir_left}, 12'd0);

        // Mid-scan reset: drive an opaque pixel, then reset
        load_pos(11'd100, 11'd50);
        x = 11'd120; y = 11'd60; vin_rgb = 12'h444;
        mem[{6'd10, 6'd20}] = 12'h0C0;
        step(); step();
        check("pre_on", {11'd0, sprite_on}, 12'd1);
        check("pre_rgb", vout_rgb, 12'h0C0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_vout", vout_rgb, 12'h000);
        check("mr_on", {11'd0, sprite_on}, 12'd0);
        check("mr_ex", {1'b0, enemy_x}, 12'd0);
        check("mr_ey", {1'b0, enemy_y}, 12'd0);
        step();
        check("mr1_vout", vout_rgb, 12'h000);
        step();
        // Enemy now at (0,0); (120,60) is outside, so video passes through.
        check("mr2_vout", vout_rgb, 12'h444);
        check("mr2_on", {11'd0, sprite_on}, 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enemy_sprite_gen.md
Name: enemy_sprite_gen

Overview:
- Pixel-generation stage directly downstream of the enemy sprite RAM: drives the RAM read address from the scan position and the enemy position, consumes the registered RAM read data, applies chroma-key transparency and overlays the result on incoming video.
- Also owns the enemy's on-screen position: a left/right patrol state machine updated once per frame.
- Sits in the video pipeline between the background generator and the VGA output mux.

Parameters:
- CD, 12, colour depth (RAM data width)
- ADDR, 12, sprite RAM address width; sprite is square, side W = 2**(ADDR/2) (64)
- KEY_COLOR, 12'hF0F, transparent colour
- H_SIZE, 640, visible width in pixels
- SPEED, 1, pixels moved per frame tick

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  11  current scan column
- y  in  11  current scan row
- frame_tick  in  1  one-cycle pulse at frame start
- move_en  in  1  patrol enable
- pos_wr  in  1  load position strobe
- pos_x  in  11  position load value, x
- pos_y  in  11  position load value, y
- ram_addr  out  ADDR  sprite RAM read address
- ram_dout  in  CD  sprite RAM read data (valid 1 cycle after ram_addr)
- vin_rgb  in  CD  incoming video
- vout_rgb  out  CD  composited video
- sprite_on  out  1  opaque sprite pixel present in vout_rgb
- enemy_x  out  11  current top-left x
- enemy_y  out  11  current top-left y
- dir_left  out  1  1 = patrol moving left

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values:
  - enemy_x = 0, enemy_y = 0, state RIGHT (dir_left = 0).
  - vout_rgb = 0, sprite_on = 0.
  - All pipeline registers cleared.
- Hit test, combinational on the current x,y:
  - hit = (enemy_x <= x <= enemy_x+W-1) and (enemy_y <= y <= enemy_y+H-1), with H = W.
  - Compare in 12-bit arithmetic so enemy_x+W cannot overflow.
- ram_addr, combinational: {dy[ADDR/2-1:0], dx[ADDR/2-1:0]}, where dx = x-enemy_x and dy = y-enemy_y. Forced to 0 when hit = 0.
- Pipeline: stage 1 registers hit and vin_rgb; stage 2 registers outputs:
  - If hit_d1 and ram_dout != KEY_COLOR: vout_rgb = ram_dout, sprite_on = 1.
  - Otherwise: vout_rgb = vin_rgb_d1, sprite_on = 0.
- Latency: x/y/vin_rgb at cycle t appear on vout_rgb/sprite_on at cycle t+2. No bubbles; one pixel per clock.
- Patrol FSM, states RIGHT and LEFT. Advances only on cycles where frame_tick = 1 and move_en = 1.
  - RIGHT: if enemy_x + W + SPEED > H_SIZE, set enemy_x = H_SIZE-W and go LEFT; else enemy_x += SPEED.
  - LEFT: if enemy_x < SPEED, set enemy_x = 0 and go RIGHT; else enemy_x -= SPEED.
  - enemy_y is never changed by the FSM.
- pos_wr:
  - Loads enemy_x = pos_x and enemy_y = pos_y; state is unchanged.
  - Has priority over a simultaneous frame_tick, which is then ignored for that cycle.
  - pos_x > H_SIZE-W is accepted as written. The next RIGHT tick clamps it to H_SIZE-W and turns LEFT.
- move_en = 0: position and state hold; rendering continues.
- Position changes only at frame_tick/pos_wr, so a frame never tears except through a mid-frame pos_wr, which is allowed and immediate.
- Reset mid-frame: outputs read 0 for the 2 cycles following reset deassertion while the pipeline refills from vin_rgb.
- dir_left = (state == LEFT).

Test Plan:
- Reset, then x=5, y=5, vin_rgb=12'h123, default position (0,0), RAM word 0x145 = 12'h0A0: ram_addr=0x145 same cycle; two cycles later vout_rgb=12'h0A0, sprite_on=1.
- Same setup with the addressed RAM word = 12'hF0F: vout_rgb=12'h123, sprite_on=0.
- pos_wr with pos_x=100, pos_y=50; scan x=99 and x=164 (outside), x=100 and x=163 (inside), y=50: ram_addr=0 outside and {6'd0,6'd0}/{6'd0,6'd63} inside; sprite_on only for inside pixels.
- pos_x=575, move_en=1, one frame_tick: enemy_x=576, dir_left=0. Next tick: enemy_x=576, dir_left=1. Next tick: enemy_x=575.
- pos_x=0 in LEFT, frame_tick: enemy_x=0, dir_left=0. pos_wr and frame_tick in the same cycle with pos_x=10: enemy_x=10, no move applied.
- move_en=0 over 3 frame_ticks: enemy_x and state unchanged. Assert reset mid-scan: all outputs 0 the next cycle, enemy_x=0.
